// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised single-clock FIFO with a true DEPTH-entry capacity.
// It provides an occupancy count, almost-full/almost-empty thresholds and
// one-cycle overflow/underflow error pulses.
// Optional feature macro: SYNC_FIFO_FWFT_EN selects first-word fall-through.
// When the macro is undefined, reads have one cycle of latency through a data_out register.
// Reads and writes in the same cycle are defined in every state, including full and empty.
module sync_fifo_param #(
   parameter  int WIDTH    = 8,
   parameter  int DEPTH    = 16,
   parameter  int AF_LEVEL = DEPTH - 2,
   parameter  int AE_LEVEL = 2,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             write_en,
   input  logic             read_en,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [AW:0]      count,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             full_r;
   logic             empty_r;
   logic             almost_full_r;
   logic             almost_empty_r;
   logic             overflow_r;
   logic             underflow_r;

   logic             rd_ok_s;
   logic             wr_ok_s;
   logic [AW:0]      count_next_s;

   // Accept decisions and next occupancy; a write into a full FIFO is allowed when a read frees a slot in the same cycle.
   always_comb begin
      rd_ok_s      = read_en && !empty_r;
      wr_ok_s      = write_en && (!full_r || rd_ok_s);
      count_next_s = count_r;
      case ({wr_ok_s, rd_ok_s})
         2'b10:   count_next_s = count_r + (AW+1)'(1);
         2'b01:   count_next_s = count_r - (AW+1)'(1);
         default: count_next_s = count_r;
      endcase
   end

   // Pointers, count, registered flags and error pulses; flags are decoded from the next count so they match count exactly.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_r       <= {AW{1'b0}};
         rd_ptr_r       <= {AW{1'b0}};
         count_r        <= {(AW+1){1'b0}};
         full_r         <= 1'b0;
         empty_r        <= 1'b1;
         almost_full_r  <= 1'b0;
         almost_empty_r <= 1'b1;
         overflow_r     <= 1'b0;
         underflow_r    <= 1'b0;
      end else begin
         if (wr_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (rd_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         count_r        <= count_next_s;
         full_r         <= (count_next_s == DEPTH_C);
         empty_r        <= (count_next_s == {(AW+1){1'b0}});
         almost_full_r  <= (count_next_s >= AF_C);
         almost_empty_r <= (count_next_s <= AE_C);
         overflow_r     <= write_en && !wr_ok_s;
         underflow_r    <= read_en && !rd_ok_s;
      end
   end

   // Storage array write port; contents are deliberately left unreset.
   always_ff @(posedge clock) begin
      if (wr_ok_s) begin
         mem_r[wr_ptr_r] <= data_in;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Fall-through head: the oldest word is shown whenever the FIFO holds data, and zero otherwise.
   always_comb begin
      if (empty_r) begin
         data_out = {WIDTH{1'b0}};
      end else begin
         data_out = mem_r[rd_ptr_r];
      end
   end
`else
   logic [WIDTH-1:0] data_out_r;

   // Read data register: it captures the popped word and holds it until the next accepted read.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_out_r <= {WIDTH{1'b0}};
      end else if (rd_ok_s) begin
         data_out_r <= mem_r[rd_ptr_r];
      end else begin
         data_out_r <= data_out_r;
      end
   end

   assign data_out = data_out_r;
`endif

   assign full         = full_r;
   assign empty        = empty_r;
   assign almost_full  = almost_full_r;
   assign almost_empty = almost_empty_r;
   assign count        = count_r;
   assign overflow     = overflow_r;
   assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: table-driven and scoreboard-checked bench for sync_fifo_param (WIDTH=8, DEPTH=16).
module tb_sync_fifo_param;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [WIDTH-1:0] data_in = 8'h00;
   logic             write_en = 1'b0;
   logic             read_en = 1'b0;
   logic [WIDTH-1:0] data_out;
   logic             full, empty, almost_full, almost_empty, overflow, underflow;
   logic [AW:0]      count;

   int num_checks = 0;
   int num_errors = 0;

   // Reference model state
   logic [7:0] q[$];
   int         m_count = 0;
   logic [7:0] m_dout = 8'h00;
   logic       m_of = 1'b0;
   logic       m_uf = 1'b0;

   typedef struct {
      logic       we;
      logic       re;
      logic [7:0] din;
      int         exp_count;
      logic       exp_af;
      logic       exp_full;
      logic       exp_of;
   } vec_t;

   vec_t vecs[18];

   sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .data_in(data_in), .write_en(write_en),
      .read_en(read_en), .data_out(data_out), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      num_checks++;
      if (act !== exp) begin
         num_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_data();
`ifdef SYNC_FIFO_FWFT_EN
      if (q.size() > 0) return q[0];
      return 8'h00;
`else
      return m_dout;
`endif
   endfunction

   task automatic check_all();
      chk("count", 32'(count), 32'(m_count));
      chk("full", 32'(full), 32'(m_count == DEPTH));
      chk("empty", 32'(empty), 32'(m_count == 0));
      chk("almost_full", 32'(almost_full), 32'(m_count >= DEPTH - 2));
      chk("almost_empty", 32'(almost_empty), 32'(m_count <= 2));
      chk("overflow", 32'(overflow), 32'(m_of));
      chk("underflow", 32'(underflow), 32'(m_uf));
      chk("data_out", 32'(data_out), 32'(exp_data()));
   endtask

   task automatic model_reset();
      q.delete();
      m_count = 0;
      m_dout = 8'h00;
      m_of = 1'b0;
      m_uf = 1'b0;
   endtask

   // One clock: drive request, update the model at the edge, compare 1 time unit later.
   task automatic step(input logic we, input logic re, input logic [7:0] din);
      logic rd_ok, wr_ok;
      write_en = we;
      read_en  = re;
      data_in  = din;
      @(posedge clock);
      rd_ok = re && (m_count != 0);
      wr_ok = we && ((m_count != DEPTH) || rd_ok);
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(din);
      if (wr_ok && !rd_ok) m_count++;
      if (rd_ok && !wr_ok) m_count--;
      m_of = we && !wr_ok;
      m_uf = re && !rd_ok;
      #1;
      check_all();
      write_en = 1'b0;
      read_en  = 1'b0;
   endtask

   initial begin
      // Table of fill-phase vectors with hand-derived expectations
      for (int i = 0; i < 16; i++) begin
         vecs[i] = '{we: 1'b1, re: 1'b0, din: 8'(i + 1), exp_count: i + 1,
                     exp_af: (i + 1 >= 14), exp_full: (i + 1 == 16), exp_of: 1'b0};
      end
      vecs[16] = '{we: 1'b1, re: 1'b0, din: 8'hAA, exp_count: 16, exp_af: 1'b1, exp_full: 1'b1, exp_of: 1'b1};
      vecs[17] = '{we: 1'b0, re: 1'b0, din: 8'h00, exp_count: 16, exp_af: 1'b1, exp_full: 1'b1, exp_of: 1'b0};

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check_all();
      @(negedge clock);
      reset = 1'b1;
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);

      // Fill to full and overflow
      for (int i = 0; i < 18; i++) begin
         step(vecs[i].we, vecs[i].re, vecs[i].din);
         chk("tbl_count", 32'(count), 32'(vecs[i].exp_count));
         chk("tbl_almost_full", 32'(almost_full), 32'(vecs[i].exp_af));
         chk("tbl_full", 32'(full), 32'(vecs[i].exp_full));
         chk("tbl_overflow", 32'(overflow), 32'(vecs[i].exp_of));
      end

      // Drain in order, then underflow
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
         chk("drain_data", 32'(data_out), 32'(i + 1));
`endif
      end
      chk("drain_empty", 32'(empty), 32'd1);
      step(1'b0, 1'b1, 8'h00);
      chk("uf_pulse", 32'(underflow), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
      chk("uf_hold", 32'(data_out), 32'h10);
`endif
      step(1'b0, 1'b0, 8'h00);
      chk("uf_clear", 32'(underflow), 32'd0);

      // Simultaneous write/read at full
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
      step(1'b1, 1'b1, 8'h55);
      chk("full_wr_rd_count", 32'(count), 32'd16);
      chk("full_wr_rd_of", 32'(overflow), 32'd0);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
      chk("last_is_55", 32'(data_out), 32'h55);
`endif

      // Simultaneous write/read at empty
      step(1'b1, 1'b1, 8'h66);
      chk("empty_wr_rd_uf", 32'(underflow), 32'd1);
      chk("empty_wr_rd_count", 32'(count), 32'd1);

      // Wrap-around at constant occupancy of 3
      step(1'b1, 1'b0, 8'h67);
      step(1'b1, 1'b0, 8'h68);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b1, 8'(8'h80 + i));
         chk("wrap_count", 32'(count), 32'd3);
      end

      // Reset mid-burst at count 9
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
      chk("pre_reset_count", 32'(count), 32'd9);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge clock);
      reset = 1'b1;
      step(1'b1, 1'b0, 8'h99);
      step(1'b0, 1'b1, 8'h00);
      chk("post_reset_data", 32'(data_out), 32'h99);
      chk("post_reset_empty", 32'(empty), 32'd1);

      // Head visibility before read, then pop
      step(1'b1, 1'b0, 8'h77);
      step(1'b0, 1'b0, 8'h00);
`ifdef SYNC_FIFO_FWFT_EN
      chk("fwft_head", 32'(data_out), 32'h77);
`endif
      step(1'b0, 1'b1, 8'h00);
      chk("pop_77_empty", 32'(empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
